pc_sel_controller: RTL and testbench

Next-PC sequencing controller for the fetch stage. It consumes control-transfer resolutions from decode/execute and the hazard unit's stall. It drives the 2-bit select code of the next-PC mux (PC+4 / jump-JAL / branch / JR), the PC write enable and the IF/ID flush. It waits for the JR source operand, holds redirects across stalls, and counts taken redirects.

---
 rtl/pc_sel_controller.sv | 136 +++++++++++++
 tb/tb_pc_sel_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sel_controller.sv
// Next-PC sequencing controller: selects the next-PC source and gates the PC write.
// It also drives the IF/ID flush and counts issued redirects.
module pc_sel_controller #(
  parameter int unsigned FlushCycles = 1,
  parameter int unsigned CntW        = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic            is_jump_i,
  input  logic            is_branch_i,
  input  logic            branch_taken_i,
  input  logic            is_jr_i,
  input  logic            jr_ready_i,
  input  logic            stall_i,
  output logic [1:0]      sel_o,
  output logic            pc_write_o,
  output logic            flush_o,
  output logic            busy_o,
  output logic [CntW-1:0] redirect_count_o
);

  typedef enum logic [1:0] {StRun, StJrWait, StRedirect, StFlush} state_e;

  localparam bit         HasFlush  = (FlushCycles > 1);
  localparam logic [2:0] FlushLoad = 3'(FlushCycles - 1);

  state_e          state_q;
  logic [1:0]      sel_q, pend_q;
  logic            flush_q, busy_q, wr_en_q;
  logic [2:0]      fcnt_q;
  logic [CntW-1:0] count_q, count_inc;

  logic [1:0] ev_code;
  logic       ev_redirect, ev_jr_wait;

  // Decode with priority JR > jump > branch; anything else is not-taken.
  always_comb begin
    ev_code     = 2'b00;
    ev_redirect = 1'b0;
    ev_jr_wait  = 1'b0;
    if (ex_valid_i) begin
      if (is_jr_i) begin
        if (jr_ready_i) begin
          ev_code     = 2'b11;
          ev_redirect = 1'b1;
        end else begin
          ev_jr_wait  = 1'b1;
        end
      end else if (is_jump_i) begin
        ev_code     = 2'b01;
        ev_redirect = 1'b1;
      end else if (is_branch_i && branch_taken_i) begin
        ev_code     = 2'b10;
        ev_redirect = 1'b1;
      end
    end
  end

  assign count_inc = (count_q == '1) ? count_q : count_q + CntW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      sel_q   <= 2'b00;
      pend_q  <= 2'b00;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b1;
      fcnt_q  <= 3'd0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ev_redirect) begin
            state_q <= StRedirect;
            pend_q  <= ev_code;
            sel_q   <= ev_code;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= count_inc;
          end else if (ev_jr_wait) begin
            state_q <= StJrWait;
            busy_q  <= 1'b1;
            wr_en_q <= 1'b0;
          end
        end
        StJrWait: begin
          if (jr_ready_i) begin
            state_q <= StRedirect;
            pend_q  <= 2'b11;
            sel_q   <= 2'b11;
            flush_q <= 1'b1;
            wr_en_q <= 1'b1;
            count_q <= count_inc;
          end
        end
        StRedirect: begin
          if (stall_i) begin
            sel_q <= pend_q;
          end else if (HasFlush) begin
            state_q <= StFlush;
            sel_q   <= 2'b00;
            fcnt_q  <= FlushLoad;
          end else begin
            state_q <= StRun;
            sel_q   <= 2'b00;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        StFlush: begin
          // Stalled cycles stretch the flush without consuming the count.
          if (!stall_i) begin
            if (fcnt_q == 3'd1) begin
              state_q <= StRun;
              flush_q <= 1'b0;
              busy_q  <= 1'b0;
              fcnt_q  <= 3'd0;
            end else begin
              fcnt_q <= fcnt_q - 3'd1;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign sel_o            = sel_q;
  assign flush_o          = flush_q;
  assign busy_o           = busy_q;
  assign pc_write_o       = wr_en_q & ~stall_i & ~rst_i;
  assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_sel_controller.sv
// Directed plus random bench for pc_sel_controller, checked against a
// cycle-level behavioural model of redirect/flush bookkeeping.
module tb_pc_sel_controller;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 2;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, ex_valid, is_jump, is_branch, branch_taken, is_jr, jr_ready, stall;
  logic [1:0]       sel;
  logic             pc_write, flush, busy;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;

  // Model: pending target code (0 = none), flush cycles left, JR wait flag.
  int m_pend       = 0;
  int m_flush_left = 0;
  bit m_wait       = 0;
  int m_count      = 0;
  bit m_valid      = 0;

  always #5 clk = ~clk;

  pc_sel_controller #(
    .FlushCycles(FLUSH_CYCLES),
    .CntW       (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (ex_valid),
    .is_jump_i       (is_jump),
    .is_branch_i     (is_branch),
    .branch_taken_i  (branch_taken),
    .is_jr_i         (is_jr),
    .jr_ready_i      (jr_ready),
    .stall_i         (stall),
    .sel_o           (sel),
    .pc_write_o      (pc_write),
    .flush_o         (flush),
    .busy_o          (busy),
    .redirect_count_o(count)
  );

  function automatic void chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    if (rst) begin
      m_pend = 0; m_flush_left = 0; m_wait = 0; m_count = 0;
    end else if (m_pend != 0) begin
      if (!stall) begin
        m_pend = 0;
        m_flush_left = m_flush_left - 1;
      end
    end else if (m_flush_left > 0) begin
      if (!stall) m_flush_left = m_flush_left - 1;
    end else if (m_wait) begin
      if (jr_ready) begin
        m_wait = 0; m_pend = 3; m_flush_left = FLUSH_CYCLES;
        m_count = (m_count < CNT_MAX) ? m_count + 1 : m_count;
      end
    end else if (ex_valid) begin
      int code = 0;
      if (is_jr) begin
        if (jr_ready) code = 3;
        else m_wait = 1;
      end else if (is_jump) code = 1;
      else if (is_branch && branch_taken) code = 2;
      if (code != 0) begin
        m_pend = code; m_flush_left = FLUSH_CYCLES;
        m_count = (m_count < CNT_MAX) ? m_count + 1 : m_count;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit ev, input bit j, input bit b, input bit t,
                       input bit jr, input bit rdy, input bit st);
    rst = r; ex_valid = ev; is_jump = j; is_branch = b; branch_taken = t;
    is_jr = jr; jr_ready = rdy; stall = st;
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    if (m_valid) begin
      chk({tag, ".sel"},      int'(sel),      m_pend);
      chk({tag, ".pc_write"}, int'(pc_write), int'(!rst && !m_wait && !stall));
      chk({tag, ".flush"},    int'(flush),    int'(m_flush_left > 0));
      chk({tag, ".busy"},     int'(busy),     int'(m_wait || m_flush_left > 0));
      chk({tag, ".count"},    int'(count),    m_count);
    end
    @(posedge clk);
    model_edge();
    m_valid = 1;
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    // Reset held for two edges; checks start once state is defined.
    tick("reset");
    tick("reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick("post_reset");

    // Jump with no stall.
    idle("pre_jump", 2);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    tick("jump_ev");
    idle("jump", 4);

    // Taken branch captured under stall; wrong-path pulses while held.
    drive(0, 1, 0, 1, 1, 0, 0, 1);
    tick("br_stall_ev");
    drive(0, 1, 1, 0, 0, 0, 0, 1);
    tick("br_stall_hold");
    drive(0, 1, 1, 0, 0, 0, 0, 1);
    tick("br_stall_hold");
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    tick("br_stall_release");
    idle("br_stall", 3);

    // JR waiting for its operand, then a not-taken branch.
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    tick("jr_ev");
    drive(0, 1, 1, 0, 0, 0, 0, 1);
    tick("jr_wait");
    idle("jr_wait", 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick("jr_ready");
    idle("jr", 3);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    tick("nt_branch");
    idle("nt_branch", 2);

    // All type bits set: JR wins.
    drive(0, 1, 1, 1, 1, 1, 1, 0);
    tick("prio_ev");
    idle("prio", 3);

    // Reset while in REDIRECT.
    drive(0, 1, 1, 0, 0, 0, 0, 1);
    tick("mid_rst_ev");
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick("mid_rst");
    idle("after_mid_rst", 2);

    // Saturation with a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      tick("sat_ev");
      idle("sat", 3);
    end
    chk("sat_final", int'(count), CNT_MAX);

    // Random traffic, including rare resets mid-flight.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(9) < 4), $urandom_range(1),
            $urandom_range(1), $urandom_range(1), ($urandom_range(3) == 0),
            ($urandom_range(2) == 0), ($urandom_range(9) < 3));
      tick("rand");
    end
    idle("drain", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
